// File: rtl/gfx_cmd_issuer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gfx_cmd_issuer: buffers host graphics commands and posts them one at a  |
// | time on cmd/cmd_hi, waiting for the controller's cmd_lo ack counter.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module gfx_cmd_issuer #(
  parameter int unsigned DEPTH   = 8,
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic                     clk_50,
  input  logic                     reset_n,
  input  logic [31:0]              in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [31:0]              cmd,
  output logic [31:0]              cmd_hi,
  input  logic [31:0]              cmd_lo,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);
  localparam logic [23:0] TMO_MAX = TIMEOUT - 24'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     cmd_q, cmd_d;
  logic [7:0]      seq_q, seq_d;
  logic [7:0]      s1_q, s2_q;
  logic [23:0]     tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            push, pop, ack, err_set;
  logic            unused_cmd_lo;

  assign unused_cmd_lo = ^cmd_lo[31:8];

  assign push = in_valid && in_ready;
  assign pop  = (state_q == ST_LOAD);
  // Two matching samples in a row guard against a multi-bit skewed capture.
  assign ack  = (s1_q == seq_q) && (s2_q == seq_q);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cmd_d    = cmd_q;
    seq_d    = seq_q;
    tmo_d    = tmo_q;
    err_set  = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cmd_d   = mem_q[rd_ptr_q];
        state_d = ST_ARM;
      end
      ST_ARM: begin
        seq_d   = seq_q + 8'd1;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack) begin
          state_d = (level_q != '0) ? ST_LOAD : ST_IDLE;
        end else if (tmo_q != TMO_MAX) begin
          // Error fires once, on the cycle the counter lands on its ceiling.
          tmo_d   = tmo_q + 24'd1;
          err_set = (tmo_d == TMO_MAX);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cmd_q    <= '0;
      seq_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cmd_q    <= cmd_d;
      seq_q    <= seq_d;
      s1_q     <= cmd_lo[7:0];
      s2_q     <= s1_q;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk_50) begin
    if (push) mem_q[wr_ptr_q] <= in_cmd;
  end

  assign in_ready    = (level_q != FULL);
  assign cmd         = cmd_q;
  assign cmd_hi      = {24'h0, seq_q};
  assign busy        = (state_q != ST_IDLE) || (level_q != '0);
  assign fifo_level  = level_q;
  assign timeout_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gfx_cmd_issuer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_gfx_cmd_issuer: self-checking bench for gfx_cmd_issuer.              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_gfx_cmd_issuer;

  logic        clk_50 = 1'b0;
  logic        reset_n;
  logic [31:0] in_cmd;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] cmd;
  logic [31:0] cmd_hi;
  logic [31:0] cmd_lo;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        timeout_err;
  logic        err_clr;

  logic        auto_ack;
  logic [31:0] man_lo;

  always #5 clk_50 = ~clk_50;

  // Controller model: either echoes cmd_hi straight back or is driven by hand.
  assign cmd_lo = auto_ack ? {24'h0, cmd_hi[7:0]} : man_lo;

  gfx_cmd_issuer #(.DEPTH(8), .TIMEOUT(24'd16)) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .in_cmd      (in_cmd),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cmd         (cmd),
    .cmd_hi      (cmd_hi),
    .cmd_lo      (cmd_lo),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  typedef struct {
    logic [31:0] word;
    logic [3:0]  exp_level;
    logic        exp_ready;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] sb [$];
  int          total = 0;
  int          bad   = 0;
  int          posts = 0;
  logic        mon_en = 1'b0;
  logic        pend;
  logic [31:0] prev_cmd;
  logic [31:0] prev_hi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every cycle advance goes through here so the post monitor sees each sample.
  task automatic tick();
    @(posedge clk_50);
    #1;
    if (mon_en) begin
      if (pend) chk("cmd_in_wait", 32'(cmd_hi != prev_hi), 32'd1);
      if (cmd_hi != prev_hi) begin
        posts++;
        chk("seq_step", cmd_hi, {24'h0, prev_hi[7:0] + 8'd1});
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL post_order: got %h expected none", cmd);
        end else begin
          chk("post_order", cmd, sb.pop_front());
        end
      end
      pend     = (cmd != prev_cmd);
      prev_cmd = cmd;
      prev_hi  = cmd_hi;
    end
  endtask

  task automatic push(input logic [31:0] w);
    int n = 0;
    in_cmd   = w;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    chk("push_ready", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back(w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_hi(input int k);
    int n = 0;
    while (cmd_hi != 32'(k) && n < 300) begin
      tick();
      n++;
    end
    chk("wait_hi", cmd_hi, 32'(k));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      tick();
      n++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_cmd   = '0;
    err_clr  = 1'b0;
    auto_ack = 1'b0;
    man_lo   = '0;
    repeat (2) tick();
    reset_n  = 1'b1;
    sb.delete();
    posts    = 0;
    prev_cmd = cmd;
    prev_hi  = cmd_hi;
    pend     = 1'b0;
    mon_en   = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  op;

    vecs[0] = '{32'h0000_4101, 4'd0, 1'b1};
    vecs[1] = '{32'h1234_5605, 4'd1, 1'b1};
    vecs[2] = '{32'hABCD_EF06, 4'd2, 1'b1};
    vecs[3] = '{32'h0000_4201, 4'd3, 1'b1};
    vecs[4] = '{32'h00FF_0005, 4'd4, 1'b1};
    vecs[5] = '{32'h0000_FF06, 4'd5, 1'b1};
    vecs[6] = '{32'h0000_4301, 4'd6, 1'b1};
    vecs[7] = '{32'h7F7F_7F05, 4'd7, 1'b1};
    vecs[8] = '{32'h0102_0306, 4'd8, 1'b0};
    vecs[9] = '{32'h0000_4401, 4'd8, 1'b0};

    // 1: reset with random inputs
    reset_n  = 1'b0;
    auto_ack = 1'b0;
    pend     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom());
      in_cmd   = $urandom();
      err_clr  = 1'($urandom());
      man_lo   = $urandom();
      tick();
    end
    chk("rst_cmd", cmd, 32'd0);
    chk("rst_cmd_hi", cmd_hi, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    do_reset();

    // 2: single post latency and ack-to-idle timing
    push(32'h0000_4101);
    chk("t2_level", 32'(fifo_level), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    tick();
    chk("t2_cmd_load", cmd, 32'd0);
    tick();
    chk("t2_cmd", cmd, 32'h0000_4101);
    chk("t2_hi_hold", cmd_hi, 32'd0);
    tick();
    chk("t2_hi", cmd_hi, 32'd1);
    repeat (3) tick();
    man_lo = 32'd1;
    repeat (2) tick();
    chk("t2_busy_a2", 32'(busy), 32'd1);
    tick();
    chk("t2_idle_a3", 32'(busy), 32'd0);

    // 3: fill and order with withheld acks
    do_reset();
    push(vecs[0].word);
    wait_hi(1);
    for (int i = 1; i < 9; i++) begin
      push(vecs[i].word);
      chk("t3_level", 32'(fifo_level), 32'(vecs[i].exp_level));
      chk("t3_ready", 32'(in_ready), 32'(vecs[i].exp_ready));
    end
    in_cmd   = vecs[9].word;
    in_valid = 1'b1;
    chk("t3_full_ready", 32'(in_ready), 32'(vecs[9].exp_ready));
    tick();
    in_valid = 1'b0;
    chk("t3_full_level", 32'(fifo_level), 32'(vecs[9].exp_level));
    man_lo = 32'd1;
    push(vecs[9].word);
    for (int k = 2; k <= 10; k++) begin
      wait_hi(k);
      man_lo = 32'(k);
    end
    wait_idle();
    chk("t3_final_hi", cmd_hi, 32'd10);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // 4: 300 posts across the sequence wrap
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r  = $urandom();
      op = (i % 3 == 0) ? 8'h01 : ((i % 3 == 1) ? 8'h05 : 8'h06);
      push({r[31:8], op});
    end
    wait_idle();
    chk("t4_final_hi", cmd_hi, 32'd44);
    chk("t4_posts", 32'(posts), 32'd300);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: timeout, set-over-clear priority, then clear and ack
    do_reset();
    push(32'h0000_4501);
    wait_hi(1);
    repeat (14) tick();
    chk("t5_err_early", 32'(timeout_err), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_set_wins", 32'(timeout_err), 32'd1);
    repeat (3) tick();
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    chk("t5_cmd_hold", cmd, 32'h0000_4501);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_clr", 32'(timeout_err), 32'd0);
    repeat (2) tick();
    chk("t5_no_reset", 32'(timeout_err), 32'd0);
    man_lo = 32'd1;
    wait_idle();
    chk("t5_err_end", 32'(timeout_err), 32'd0);

    // 6: one-cycle glitch on cmd_lo must not acknowledge
    do_reset();
    push(32'h00AB_CD05);
    wait_hi(1);
    repeat (3) tick();
    man_lo = 32'd1;
    tick();
    man_lo = 32'd0;
    repeat (6) tick();
    chk("t6_glitch_busy", 32'(busy), 32'd1);
    man_lo = 32'd1;
    repeat (2) tick();
    chk("t6_busy_a2", 32'(busy), 32'd1);
    tick();
    chk("t6_idle_a3", 32'(busy), 32'd0);

    // asynchronous reset while a post is outstanding
    push(32'h0000_4601);
    wait_hi(2);
    mon_en  = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_cmd", cmd, 32'd0);
    chk("async_hi", cmd_hi, 32'd0);
    chk("async_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
